// File: rtl/vending_machine_param.sv
// Parametrised vending controller: N items, per-item price/stock, 5/10/20 coins, serial 5-rupee change.
// Optional idle auto-refund is built only when AUTO_REFUND_TIMEOUT_EN is defined.

module vending_stock_cell #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restock,
  input  logic i_dec,
  output logic o_empty
);
  logic [STOCK_W-1:0] r_stock, w_stock_nxt;

  always_comb begin
    w_stock_nxt = r_stock;
    if (i_restock)                  w_stock_nxt = STOCK_W'(STOCK_INIT);
    else if (i_dec && r_stock != 0) w_stock_nxt = r_stock - 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stock <= STOCK_W'(STOCK_INIT);
      o_empty <= (STOCK_INIT == 0);
    end else begin
      r_stock <= w_stock_nxt;
      o_empty <= (w_stock_nxt == '0);
    end
endmodule

module vending_machine_param #(
  parameter int                            NUM_ITEMS      = 4,
  parameter int                            PRICE_W        = 7,
  parameter logic [NUM_ITEMS*PRICE_W-1:0]  PRICES         = {7'd30, 7'd25, 7'd20, 7'd15},
  parameter int                            MAX_CREDIT     = 95,
  parameter int                            STOCK_W        = 4,
  parameter int                            STOCK_INIT     = 3,
  parameter int                            TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 five_rup,
  input  logic                 ten_rup,
  input  logic                 twenty_rup,
  input  logic                 cancel,
  input  logic                 restock,
  input  logic [NUM_ITEMS-1:0] item_no,
  output logic [NUM_ITEMS-1:0] product,
  output logic [PRICE_W-1:0]   change,
  output logic                 change_coin,
  output logic [PRICE_W-1:0]   credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 coin_reject,
  output logic                 err_invalid,
  output logic                 busy
);
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE, S_REFUND} state_t;

  localparam logic [PRICE_W:0]   MAXC = (PRICE_W+1)'(MAX_CREDIT);
  localparam logic [PRICE_W-1:0] C5   = PRICE_W'(5);

  if (MAX_CREDIT % 5 != 0) begin : g_bad_max
    $error("MAX_CREDIT must be a multiple of 5");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t               r_state, w_state_nxt;
  logic [1:0]           w_coin_cnt;
  logic [PRICE_W:0]     w_coin_val, w_sum;
  logic [PRICE_W-1:0]   w_sel_price;
  logic                 w_item_multi, w_item_one, w_in_stock;
  logic                 w_vend, w_refund, w_timeout, w_coin_acc, w_coin_rej;
  logic [NUM_ITEMS-1:0] w_dec;
  logic                 w_restock;

  assign w_coin_cnt   = {1'b0, five_rup} + {1'b0, ten_rup} + {1'b0, twenty_rup};
  assign w_coin_val   = five_rup ? (PRICE_W+1)'(5) : ten_rup ? (PRICE_W+1)'(10) :
                        twenty_rup ? (PRICE_W+1)'(20) : '0;
  assign w_sum        = {1'b0, credit} + w_coin_val;
  assign w_item_multi = |(item_no & (item_no - 1'b1));
  assign w_item_one   = (|item_no) && !w_item_multi;
  assign w_in_stock   = |(item_no & ~sold_out);

  always_comb begin
    w_sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (item_no[i]) w_sel_price = w_sel_price | PRICES[i*PRICE_W +: PRICE_W];
  end

  // Same-cycle priority in COLLECT: cancel/timeout, then vend, then coin.
  assign w_refund   = (r_state == S_COLLECT) && ((cancel && credit != '0) || w_timeout);
  assign w_vend     = (r_state == S_COLLECT) && !w_refund && w_item_one && w_in_stock &&
                      (credit >= w_sel_price);
  assign w_coin_acc = ((r_state == S_IDLE) || (r_state == S_COLLECT && !w_refund && !w_vend)) &&
                      (w_coin_cnt == 2'd1) && (w_sum <= MAXC);
  assign w_coin_rej = (w_coin_cnt != 2'd0) && !w_coin_acc;
  assign w_dec      = w_vend ? item_no : '0;
  assign w_restock  = restock && (r_state == S_IDLE);

`ifdef AUTO_REFUND_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]      r_to_cnt;
  logic [NUM_ITEMS-1:0] r_item_prev;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_to_cnt    <= '0;
      r_item_prev <= '0;
    end else begin
      r_item_prev <= item_no;
      if (r_state != S_COLLECT || w_coin_acc || item_no != r_item_prev) r_to_cnt <= '0;
      else if (r_to_cnt != TO_LAST)                                    r_to_cnt <= r_to_cnt + 1'b1;
    end

  assign w_timeout = (r_state == S_COLLECT) && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_stock
    vending_stock_cell #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_cell (
      .clk(clk), .rst(rst), .i_restock(w_restock), .i_dec(w_dec[g]), .o_empty(sold_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_coin_acc) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_refund) w_state_nxt = S_REFUND;
                 else if (w_vend) w_state_nxt = S_VEND;
      S_VEND:    w_state_nxt = (credit == '0) ? S_IDLE : S_CHANGE;
      S_CHANGE,
      S_REFUND:  if (credit == '0) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Vend arithmetic lands on the edge entering VEND so product is high for exactly the VEND cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      credit      <= '0;
      change      <= '0;
      product     <= '0;
      change_coin <= 1'b0;
      coin_reject <= 1'b0;
      err_invalid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      product     <= '0;
      change_coin <= 1'b0;
      coin_reject <= w_coin_rej;
      err_invalid <= (r_state == S_COLLECT) && w_item_multi && !w_refund;
      busy        <= (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE) ||
                     (w_state_nxt == S_REFUND);
      if (w_coin_acc) begin
        credit <= w_sum[PRICE_W-1:0];
        change <= '0;
      end
      case (r_state)
        S_COLLECT:
          if (w_refund) change <= credit;
          else if (w_vend) begin
            product <= item_no;
            credit  <= credit - w_sel_price;
            change  <= credit - w_sel_price;
          end
        S_CHANGE, S_REFUND:
          if (credit != '0) begin
            change_coin <= 1'b1;
            credit      <= credit - C5;
          end
        default: ;
      endcase
    end
endmodule
